// File: rtl/dm_axi_master.sv
// Data-memory bus master: turns one CPU memory-stage request into a single-beat
// AXI4 read or write, returns the read word and stalls the pipeline meanwhile.
module dm_axi_master #(
  parameter int ID_WIDTH  = 4,
  parameter int MASTER_ID = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dm_on,
  input  logic [31:0]         dm_addr,
  input  logic [3:0]          dm_wstrb,
  input  logic [31:0]         dm_wdata,
  input  logic                pipe_hold,
  output logic [31:0]         dm_rdata,
  output logic                dm_stall,
  output logic                dm_resp_err,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(MASTER_ID);

  state_t      state;
  logic [29:0] word_addr;
  logic        aw_done, w_done;
  logic        aw_fire, w_fire;
  logic        unused_ok;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  assign awid    = ID_VAL;
  assign arid    = ID_VAL;
  assign awaddr  = {word_addr, 2'b00};
  assign araddr  = {word_addr, 2'b00};
  assign awlen   = 4'd0;
  assign arlen   = 4'd0;
  assign awsize  = 3'b010;
  assign arsize  = 3'b010;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wlast   = 1'b1;

  // Byte offset, IDs and rlast carry no information for a single-beat word master.
  assign unused_ok = ^{bid, rid, rlast, dm_addr[1:0]};

  assign dm_stall = (state == S_IDLE && dm_on) ||
                    (state inside {S_AR, S_R, S_AW_W, S_B});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      dm_rdata    <= 32'd0;
      dm_resp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (dm_on) begin
          word_addr <= dm_addr[31:2];
          wstrb     <= dm_wstrb;
          wdata     <= dm_wdata;
          if (dm_wstrb == 4'b0000) begin
            arvalid <= 1'b1;
            state   <= S_AR;
          end else begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= S_AW_W;
          end
        end
        S_AR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= S_R;
        end
        S_R: if (rvalid) begin
          rready      <= 1'b0;
          dm_rdata    <= rdata;
          dm_resp_err <= (rresp != 2'b00);
          state       <= S_DONE;
        end
        S_AW_W: begin
          // Address and data channels complete independently, in either order.
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= S_B;
          end else begin
            if (aw_fire) begin
              awvalid <= 1'b0;
              aw_done <= 1'b1;
            end
            if (w_fire) begin
              wvalid <= 1'b0;
              w_done <= 1'b1;
            end
          end
        end
        S_B: if (bvalid) begin
          bready      <= 1'b0;
          dm_resp_err <= (bresp != 2'b00);
          state       <= S_DONE;
        end
        // Waiting here while the pipeline is held keeps the same request from re-issuing.
        S_DONE: if (!pipe_hold) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// Randomized scoreboard bench for dm_axi_master: a reference memory model predicts
// every AXI address/data beat and every completed CPU access.
module tb_dm_axi_master;

  logic        clk, rst;
  logic        dm_on, pipe_hold;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        dm_stall, dm_resp_err;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

  dm_axi_master #(.ID_WIDTH(4), .MASTER_ID(1)) dut (
    .clk(clk), .rst(rst), .dm_on(dm_on), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .pipe_hold(pipe_hold), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .dm_resp_err(dm_resp_err), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
  typedef struct { logic [31:0] rdata; logic err; int stall; } done_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;

  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  w_exp_t      exp_w_q[$];
  done_exp_t   exp_done_q[$];
  rsp_t        s_r_q[$];
  logic [1:0]  s_b_q[$];

  logic [31:0] mem [logic [29:0]];
  logic [31:0] last_rdata;
  int          checks, errors;
  int          mode;   // 0: all readies high, 1: random, 2: wready two cycles after awready

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected handshake, nothing expected", nm);
  endtask

  // Slave: readies per mode, one queued response per accepted transaction.
  initial begin : slave
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_got, w_got;
    int r_cnt, b_cnt, w_age;
    rsp_t rr;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0; rid = 0; bid = 0; rlast = 0;
    r_cnt = -1; b_cnt = -1; w_age = 0; aw_got = 0; w_got = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
      r_hs = rvalid && rready;    b_hs = bvalid && bready;
      @(posedge clk); #2;
      if (rst) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        r_cnt = -1; b_cnt = -1; w_age = 0; aw_got = 0; w_got = 0;
      end else begin
        if (r_hs) rvalid = 0;
        if (b_hs) bvalid = 0;
        if (ar_hs) r_cnt = (mode == 1) ? $urandom_range(0, 3) : 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin
          b_cnt = (mode == 1) ? $urandom_range(0, 3) : 0;
          aw_got = 0; w_got = 0;
        end
        if (r_cnt == 0 && s_r_q.size() > 0) begin
          rr = s_r_q.pop_front();
          rvalid = 1; rdata = rr.data; rresp = rr.resp; rlast = 1; rid = 4'($urandom);
          r_cnt = -1;
        end else if (r_cnt > 0) r_cnt--;
        if (!rvalid) begin rdata = $urandom; rresp = 2'($urandom); end
        if (b_cnt == 0 && s_b_q.size() > 0) begin
          bvalid = 1; bresp = s_b_q.pop_front(); bid = 4'($urandom);
          b_cnt = -1;
        end else if (b_cnt > 0) b_cnt--;
        if (w_hs) w_age = 0;
        else if (wvalid) w_age++;
        case (mode)
          0: begin arready = 1; awready = 1; wready = 1; end
          1: begin arready = $urandom_range(0, 1); awready = $urandom_range(0, 1);
                   wready = $urandom_range(0, 1); end
          default: begin arready = 1; awready = 1; wready = (w_age >= 3); end
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake or a completion.
  initial begin : monitor
    logic prev_stall, p_arw, p_aww, p_ww;
    logic [31:0] p_araddr, p_awaddr, p_wdata, ea;
    logic [3:0] p_wstrb;
    w_exp_t ew;
    done_exp_t ed;
    int stall_cnt;
    prev_stall = 0; p_arw = 0; p_aww = 0; p_ww = 0; stall_cnt = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; p_arw = 0; p_aww = 0; p_ww = 0; stall_cnt = 0;
      end else begin
        if (p_arw) begin chk("arvalid_held", arvalid, 1); chk("araddr_stable", araddr, p_araddr); end
        if (p_aww) begin chk("awvalid_held", awvalid, 1); chk("awaddr_stable", awaddr, p_awaddr); end
        if (p_ww) begin
          chk("wvalid_held", wvalid, 1); chk("wdata_stable", wdata, p_wdata);
          chk("wstrb_stable", wstrb, p_wstrb);
        end
        if (arvalid && arready) begin
          if (exp_ar_q.size() == 0) flag("ar_extra");
          else begin
            ea = exp_ar_q.pop_front();
            chk("araddr", araddr, ea); chk("arlen", arlen, 0); chk("arsize", arsize, 2);
            chk("arburst", arburst, 1); chk("arid", arid, 1);
          end
        end
        if (awvalid && awready) begin
          if (exp_aw_q.size() == 0) flag("aw_extra");
          else begin
            ea = exp_aw_q.pop_front();
            chk("awaddr", awaddr, ea); chk("awlen", awlen, 0); chk("awsize", awsize, 2);
            chk("awburst", awburst, 1); chk("awid", awid, 1);
          end
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) flag("w_extra");
          else begin
            ew = exp_w_q.pop_front();
            chk("wdata", wdata, ew.data); chk("wstrb", wstrb, ew.strb); chk("wlast", wlast, 1);
          end
        end
        if (dm_stall) stall_cnt++;
        if (prev_stall && !dm_stall) begin
          if (exp_done_q.size() == 0) flag("done_extra");
          else begin
            ed = exp_done_q.pop_front();
            chk("dm_rdata", dm_rdata, ed.rdata);
            chk("dm_resp_err", dm_resp_err, ed.err);
            if (ed.stall > 0) chk("stall_cycles", stall_cnt, ed.stall);
          end
          stall_cnt = 0;
        end
        prev_stall = dm_stall;
        p_arw = arvalid && !arready; p_araddr = araddr;
        p_aww = awvalid && !awready; p_awaddr = awaddr;
        p_ww = wvalid && !wready;    p_wdata = wdata; p_wstrb = wstrb;
      end
    end
  end

  // Issue one CPU access: predict it, drive it, wait for DONE, optionally hold there.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [1:0] resp, input int hold, input int est);
    logic [29:0] wi;
    logic [31:0] tmp;
    done_exp_t ed;
    int cyc;
    wi = a[31:2];
    if (!mem.exists(wi)) mem[wi] = $urandom;
    if (s == 4'b0000) begin
      exp_ar_q.push_back({wi, 2'b00});
      s_r_q.push_back('{mem[wi], resp});
      last_rdata = mem[wi];
    end else begin
      exp_aw_q.push_back({wi, 2'b00});
      exp_w_q.push_back('{d, s});
      tmp = mem[wi];
      for (int b = 0; b < 4; b++) if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
      mem[wi] = tmp;
      s_b_q.push_back(resp);
    end
    ed.rdata = last_rdata; ed.err = (resp != 2'b00); ed.stall = est;
    exp_done_q.push_back(ed);
    @(posedge clk); #1;
    dm_on = 1; dm_addr = a; dm_wstrb = s; dm_wdata = d; pipe_hold = (hold > 0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (dm_stall && cyc < 200);
    if (dm_stall) begin
      errors++;
      $display("FAIL done_timeout actual=stall expected=done");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        chk("hold_arvalid", arvalid, 0); chk("hold_awvalid", awvalid, 0);
        chk("hold_stall", dm_stall, 0);  chk("hold_rdata", dm_rdata, last_rdata);
      end
      @(posedge clk); #1;
      pipe_hold = 0;
    end
  endtask

  initial begin : stim
    int cyc;
    checks = 0; errors = 0; mode = 0; last_rdata = 0;
    rst = 1; dm_on = 0; dm_addr = 0; dm_wstrb = 0; dm_wdata = 0; pipe_hold = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);   chk("rst_bready", bready, 0);   chk("rst_stall", dm_stall, 0);
    chk("rst_rdata", dm_rdata, 0);  chk("rst_err", dm_resp_err, 0);

    mode = 0;
    mem[30'h401] = 32'hDEADBEEF;
    issue(32'h0000_1006, 4'b0000, 32'h0, 2'b00, 0, 3);
    mode = 2;
    issue(32'h0000_2000, 4'b1100, 32'hAABB_0000, 2'b00, 0, 5);
    mode = 0;
    issue(32'h0000_3008, 4'b1111, 32'h1234_5678, 2'b00, 0, 3);
    issue(32'h0000_300B, 4'b0000, 32'h0, 2'b00, 0, 3);
    issue(32'h0000_1004, 4'b0000, 32'h0, 2'b00, 4, 3);
    issue(32'h0000_4000, 4'b0011, 32'h0000_BEEF, 2'b10, 0, 3);
    issue(32'h0000_4000, 4'b0000, 32'h0, 2'b00, 0, 3);
    issue(32'h0000_4004, 4'b0000, 32'h0, 2'b11, 0, 3);

    mode = 1;
    for (int n = 0; n < 40; n++)
      issue(32'h0000_1000 + $urandom_range(0, 31),
            ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15)),
            $urandom, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, 2), -1);

    // Reset while waiting in R with no read data ever returned.
    mode = 0;
    exp_ar_q.push_back(32'h0000_5000);
    @(posedge clk); #1;
    dm_on = 1; dm_addr = 32'h0000_5000; dm_wstrb = 0; pipe_hold = 0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rready && cyc < 50);
    chk("reach_r", rready, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_rready", rready, 0);  chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_stall", dm_stall, dm_on); chk("mid_rst_rdata", dm_rdata, 0);
    @(posedge clk); #1;
    rst = 0; dm_on = 0;
    last_rdata = 0;
    issue(32'h0000_1004, 4'b0000, 32'h0, 2'b00, 0, 3);

    @(posedge clk); #1;
    dm_on = 0;
    repeat (5) @(negedge clk);
    chk("ar_q_empty", exp_ar_q.size(), 0);   chk("aw_q_empty", exp_aw_q.size(), 0);
    chk("w_q_empty", exp_w_q.size(), 0);     chk("done_q_empty", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
